tracklet_projector: RTL and testbench

- Parametrised successor to the single-radius projection calculator.
- Per event, streams tracklets from a tracklet memory and projects each onto NUM_LAYERS target radii, time-multiplexed through one pipelined arithmetic datapath.
- Emits phi/z projections and derivatives with saturation, per-layer write addresses and an event-done pulse.
- Sits between the tracklet calculator memories and the per-layer projection memories.

---
 rtl/tracklet_projector.sv | 200 ++++++++++++++++++++
 tb/tb_tracklet_projector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tracklet_projector.sv
// rtl/tracklet_projector.sv - streams tracklets and projects each onto NUM_LAYERS radii
// One shared 4-stage arithmetic pipe; the layer tag rides along with the data.
module tracklet_projector #(
  parameter int NUM_LAYERS = 2,
  parameter logic [16*NUM_LAYERS-1:0] RPROJ_LIST = {16'h86a, 16'hc4e},
  parameter int ADDR_BITS = 6,
  parameter int PHI_BITS = 14,
  parameter int Z_BITS = 12,
  parameter int PHID_BITS = 9,
  parameter int ZD_BITS = 9,
  parameter int PHI_SHIFT = 10,
  parameter int Z_SHIFT = 12
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [ADDR_BITS:0]                          num_tracklets,
  output logic [ADDR_BITS-1:0]                        read_tracklet,
  output logic                                        rd_en,
  input  logic [53:0]                                 tracklet,
  output logic                                        proj_valid,
  output logic [1:0]                                  proj_layer,
  output logic [ADDR_BITS-1:0]                        write_projection,
  output logic [PHI_BITS+Z_BITS+PHID_BITS+ZD_BITS:0]  projection_calc,
  output logic                                        busy,
  output logic                                        done
);

  typedef logic signed [39:0] wide_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [ADDR_BITS:0] MAX_N = {1'b1, {ADDR_BITS{1'b0}}};

  state_t state, state_n;
  logic [ADDR_BITS-1:0] t, t_n, last_t, last_t_n;
  logic [1:0] lcnt, lcnt_n;
  logic busy_n, done_n, accept, pipe_empty;
  logic [ADDR_BITS:0] num_c;

  logic [15:0] radius [4];
  for (genvar k = 0; k < 4; k++) begin : g_radius
    if (k < NUM_LAYERS) begin : g_used
      assign radius[k] = RPROJ_LIST[16*k +: 16];
    end else begin : g_unused
      assign radius[k] = '0;
    end
  end

  assign num_c = (num_tracklets > MAX_N) ? MAX_N : num_tracklets;
  assign rd_en = (state == ISSUE);
  assign read_tracklet = t;

  always_comb begin
    state_n  = state;
    t_n      = t;
    lcnt_n   = lcnt;
    last_t_n = last_t;
    busy_n   = busy;
    done_n   = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept = 1'b1;
        if (num_tracklets == '0) begin
          done_n = 1'b1;
        end else begin
          state_n  = ISSUE;
          busy_n   = 1'b1;
          t_n      = '0;
          lcnt_n   = '0;
          last_t_n = ADDR_BITS'(num_c - 1'b1);
        end
      end
      ISSUE: begin
        if (lcnt == 2'(NUM_LAYERS - 1)) begin
          lcnt_n = '0;
          if (t == last_t) state_n = DRAIN;
          else t_n = t + 1'b1;
        end else begin
          lcnt_n = lcnt + 2'd1;
        end
      end
      DRAIN: if (pipe_empty) begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      t      <= '0;
      lcnt   <= '0;
      last_t <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      t      <= t_n;
      lcnt   <= lcnt_n;
      last_t <= last_t_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // p0 marks the cycle the memory presents data; s1..s3 are the arithmetic stages
  logic p0_v, s1_v, s2_v, s3_v;
  logic [1:0] p0_layer, s1_layer, s2_layer, s3_layer;
  logic [15:0] s1_r;
  logic signed [13:0] s1_irinv, s2_irinv;
  logic [16:0] s1_iphi0, s2_iphi0;
  logic signed [9:0] s1_iz0, s2_iz0;
  logic signed [12:0] s1_it, s2_it;
  wide_t s2_pphi, s2_pz, s3_phi, s3_z, s3_pd, s3_zd;

  assign pipe_empty = !(p0_v || s1_v || s2_v || s3_v);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_v     <= 1'b0;
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s3_v     <= 1'b0;
      p0_layer <= '0;
    end else begin
      p0_v     <= rd_en;
      p0_layer <= lcnt;
      s1_v     <= p0_v;
      s2_v     <= s1_v;
      s3_v     <= s2_v;
    end
  end

  always_ff @(posedge clk) begin
    s1_layer <= p0_layer;
    s1_r     <= radius[p0_layer];
    s1_irinv <= tracklet[53:40];
    s1_iphi0 <= tracklet[39:23];
    s1_iz0   <= tracklet[22:13];
    s1_it    <= tracklet[12:0];

    s2_layer <= s1_layer;
    s2_pphi  <= wide_t'($signed({1'b0, s1_r})) * wide_t'(s1_irinv);
    s2_pz    <= wide_t'($signed({1'b0, s1_r})) * wide_t'(s1_it);
    s2_irinv <= s1_irinv;
    s2_iphi0 <= s1_iphi0;
    s2_iz0   <= s1_iz0;
    s2_it    <= s1_it;

    s3_layer <= s2_layer;
    s3_phi   <= wide_t'({1'b0, s2_iphi0}) - (s2_pphi >>> PHI_SHIFT);
    s3_z     <= wide_t'(s2_iz0) + (s2_pz >>> Z_SHIFT);
    s3_pd    <= -(wide_t'(s2_irinv) >>> 5);
    s3_zd    <= wide_t'(s2_it) >>> 4;
  end

  function automatic wide_t sat(input wide_t v, input int bits);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (bits - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  wide_t phi_s, z_s, pd_s, zd_s;
  logic ovf;
  assign phi_s = sat(s3_phi, PHI_BITS);
  assign z_s   = sat(s3_z, Z_BITS);
  assign pd_s  = sat(s3_pd, PHID_BITS);
  assign zd_s  = sat(s3_zd, ZD_BITS);
  assign ovf   = (phi_s != s3_phi) || (z_s != s3_z) || (pd_s != s3_pd) || (zd_s != s3_zd);

  logic [ADDR_BITS-1:0] wp [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proj_valid       <= 1'b0;
      proj_layer       <= '0;
      write_projection <= '0;
      projection_calc  <= '0;
      for (int k = 0; k < 4; k++) wp[k] <= '0;
    end else begin
      proj_valid <= s3_v;
      if (accept) begin
        for (int k = 0; k < 4; k++) wp[k] <= '0;
      end else if (s3_v) begin
        proj_layer       <= s3_layer;
        write_projection <= wp[s3_layer];
        wp[s3_layer]     <= wp[s3_layer] + 1'b1;
        projection_calc  <= {ovf, PHI_BITS'(phi_s), Z_BITS'(z_s), PHID_BITS'(pd_s), ZD_BITS'(zd_s)};
      end
    end
  end

endmodule

// File: tb/tb_tracklet_projector.sv
// tb/tb_tracklet_projector.sv - scoreboard bench for tracklet_projector
// Two instances: default 2-layer build and a 1-layer, 2-bit-address build.
module tb_tracklet_projector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic st_a, rd_a, pv_a, busy_a, done_a;
  logic [6:0] num_a;
  logic [5:0] rt_a, wp_a;
  logic [53:0] trk_a;
  logic [1:0] ly_a;
  logic [44:0] calc_a;
  logic [53:0] mem_a [64];

  logic st_b, rd_b, pv_b, busy_b, done_b;
  logic [2:0] num_b;
  logic [1:0] rt_b, wp_b, ly_b;
  logic [53:0] trk_b;
  logic [44:0] calc_b;
  logic [53:0] mem_b [4];

  always @(posedge clk) trk_a <= mem_a[rt_a];
  always @(posedge clk) trk_b <= mem_b[rt_b];

  tracklet_projector u_a (
    .clk(clk), .reset(rst), .start(st_a), .num_tracklets(num_a),
    .read_tracklet(rt_a), .rd_en(rd_a), .tracklet(trk_a),
    .proj_valid(pv_a), .proj_layer(ly_a), .write_projection(wp_a),
    .projection_calc(calc_a), .busy(busy_a), .done(done_a));

  tracklet_projector #(.NUM_LAYERS(1), .RPROJ_LIST(16'h400), .ADDR_BITS(2)) u_b (
    .clk(clk), .reset(rst), .start(st_b), .num_tracklets(num_b),
    .read_tracklet(rt_b), .rd_en(rd_b), .tracklet(trk_b),
    .proj_valid(pv_b), .proj_layer(ly_b), .write_projection(wp_b),
    .projection_calc(calc_b), .busy(busy_b), .done(done_b));

  typedef struct packed {
    logic [1:0]  layer;
    logic [5:0]  waddr;
    logic [44:0] calc;
  } exp_t;
  exp_t q_a[$], q_b[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [44:0] pk(input int ovf, input int phi, input int z, input int pd, input int zd);
    return {1'(ovf), 14'(phi), 12'(z), 9'(pd), 9'(zd)};
  endfunction

  function automatic logic [53:0] mk(input int irinv, input int iphi0, input int iz0, input int it);
    return {14'(irinv), 17'(iphi0), 10'(iz0), 13'(it)};
  endfunction

  task automatic push_a(input int l, input int w, input logic [44:0] c);
    exp_t e;
    e.layer = 2'(l); e.waddr = 6'(w); e.calc = c;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int w, input logic [44:0] c);
    exp_t e;
    e.layer = 2'd0; e.waddr = 6'(w); e.calc = c;
    q_b.push_back(e);
  endtask

  int words_a = 0, last_pv_a = 0, done_cnt_a = 0;
  int words_b = 0, last_pv_b = 0, done_cnt_b = 0;

  initial begin : mon_a
    exp_t ea;
    forever begin
      @(negedge clk);
      if (rst) words_a = 0;
      else begin
        if (pv_a) begin
          if (words_a > 0) check("a_gap", cyc - last_pv_a, 1);
          check("a_queue_has_word", q_a.size() > 0, 1);
          if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            check("a_layer", ly_a, ea.layer);
            check("a_waddr", wp_a, ea.waddr);
            check("a_calc", calc_a, ea.calc);
          end
          last_pv_a = cyc;
          words_a++;
        end
        if (done_a) begin
          done_cnt_a++;
          if (words_a > 0) check("a_done_lat", cyc - last_pv_a, 1);
          words_a = 0;
        end
      end
    end
  end

  initial begin : mon_b
    exp_t eb;
    forever begin
      @(negedge clk);
      if (rst) words_b = 0;
      else begin
        if (pv_b) begin
          if (words_b > 0) check("b_gap", cyc - last_pv_b, 1);
          check("b_queue_has_word", q_b.size() > 0, 1);
          if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            check("b_layer", ly_b, eb.layer);
            check("b_waddr", wp_b, eb.waddr);
            check("b_calc", calc_b, eb.calc);
          end
          last_pv_b = cyc;
          words_b++;
        end
        if (done_b) begin
          done_cnt_b++;
          if (words_b > 0) check("b_done_lat", cyc - last_pv_b, 1);
          words_b = 0;
        end
      end
    end
  end

  task automatic run_a(input int n, input bit poke);
    int c0, w, d0;
    d0 = done_cnt_a;
    num_a = 7'(n); st_a = 1'b1;
    @(negedge clk); st_a = 1'b0;
    check("a_busy_start", busy_a, 1);
    w = 0;
    while (!rd_a && w < 10) begin @(negedge clk); w++; end
    check("a_rd_en", rd_a, 1);
    c0 = cyc;
    if (poke) begin
      num_a = 7'd5; st_a = 1'b1;
      @(negedge clk); st_a = 1'b0;
    end
    w = 0;
    while (!pv_a && w < 20) begin @(negedge clk); w++; end
    check("a_latency", cyc - c0, 5);
    w = 0;
    while (!done_a && w < 100) begin @(negedge clk); w++; end
    check("a_done", done_a, 1);
    check("a_busy_end", busy_a, 0);
    @(negedge clk);
    check("a_done_count", done_cnt_a, d0 + 1);
    check("a_queue_empty", q_a.size(), 0);
  endtask

  task automatic run_b(input int n);
    int w, d0;
    d0 = done_cnt_b;
    num_b = 3'(n); st_b = 1'b1;
    @(negedge clk); st_b = 1'b0;
    check("b_rd_en", rd_b, 1);
    w = 0;
    while (!done_b && w < 60) begin @(negedge clk); w++; end
    check("b_done", done_b, 1);
    check("b_busy_end", busy_b, 0);
    @(negedge clk);
    check("b_done_count", done_cnt_b, d0 + 1);
    check("b_queue_empty", q_b.size(), 0);
  endtask

  task automatic load_event1();
    mem_a[0] = mk(0, 4096, 5, 0);
    mem_a[1] = mk(-8192, 0, 0, 0);
    mem_a[2] = mk(100, 5000, -20, 1000);
    push_a(0, 0, pk(0, 4096, 5, 0, 0));
    push_a(1, 0, pk(0, 4096, 5, 0, 0));
    push_a(0, 1, pk(1, 8191, 0, 255, 0));
    push_a(1, 1, pk(1, 8191, 0, 255, 0));
    push_a(0, 2, pk(0, 4693, 749, -3, 62));
    push_a(1, 2, pk(0, 4790, 505, -3, 62));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; st_a = 1'b0; num_a = '0; st_b = 1'b0; num_b = '0;
    for (int i = 0; i < 64; i++) mem_a[i] = '0;
    for (int i = 0; i < 4; i++) mem_b[i] = mk(32 * i, 1000, i, 16 * i);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_proj_valid", pv_a, 0);
    check("rst_done", done_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_rd_en", rd_a, 0);
    check("rst_calc", calc_a, 0);
    check("rst_waddr", wp_a, 0);
    check("rst_read_addr", rt_a, 0);

    load_event1();
    run_a(3, 1'b1);

    mem_a[0] = mk(-1000, 100, -500, -4000);
    mem_a[1] = mk(8191, 0, 0, 0);
    push_a(0, 0, pk(1, 3177, -2048, 32, -250));
    push_a(1, 0, pk(1, 2204, -2048, 32, -250));
    push_a(0, 1, pk(1, -8192, 0, -255, 0));
    push_a(1, 1, pk(1, -8192, 0, -255, 0));
    run_a(2, 1'b0);

    d0 = done_cnt_a;
    num_a = '0; st_a = 1'b1;
    @(negedge clk); st_a = 1'b0;
    check("zero_done", done_a, 1);
    check("zero_rd_en", rd_a, 0);
    check("zero_busy", busy_a, 0);
    @(negedge clk);
    check("zero_done_single", done_a, 0);
    check("zero_done_count", done_cnt_a, d0 + 1);

    num_a = 7'd3; st_a = 1'b1;
    @(negedge clk); st_a = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt_a;
    #2 rst = 1'b1;
    q_a.delete();
    #1;
    check("arst_rd_en", rd_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_calc", calc_a, 0);
    check("arst_read_addr", rt_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_no_done", done_cnt_a, d0);
    check("arst_idle_busy", busy_a, 0);

    load_event1();
    run_a(3, 1'b0);

    push_b(0, pk(0, 1000, 0, 0, 0));
    push_b(1, pk(0, 968, 5, -1, 1));
    push_b(2, pk(0, 936, 10, -2, 2));
    push_b(3, pk(0, 904, 15, -3, 3));
    run_b(4);
    push_b(0, pk(0, 1000, 0, 0, 0));
    push_b(1, pk(0, 968, 5, -1, 1));
    push_b(2, pk(0, 936, 10, -2, 2));
    push_b(3, pk(0, 904, 15, -3, 3));
    run_b(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
